mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory/bus port between the instruction-fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between the instruction-fetch and data requesters.
// Each transaction runs grant -> hold -> ack -> recover. Data wins by default, but a fetch
// that keeps waiting gets the bus after STARVE_LIMIT data grants. TIMEOUT bounds the wait for m_ack.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_sel,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_sel,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            stallreq_if,
  output logic            stallreq_mem,
  output logic            bus_err,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DROP, RESP} state_t;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);
  localparam bit            TMO_EN     = (TIMEOUT != 0);

  state_t            state, state_d;
  logic              m_req_d, m_we_d, if_ack_d, d_ack_d, bus_err_d;
  logic [DW/8-1:0]   m_sel_d;
  logic [AW-1:0]     m_addr_d;
  logic [DW-1:0]     m_wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]     starve_cnt, starve_d;
  logic [WW-1:0]     wait_cnt, wait_d;
  logic              grant_i, grant_d, timeout_hit;

  // Handshake: a requester raises *_req with its fields stable and holds it until it sees
  // its one-cycle *_ack; on the memory side m_req/m_* stay stable until m_ack (or timeout).
  assign timeout_hit  = TMO_EN && (wait_cnt == WAIT_MAX) && !m_ack;
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = d_req & ~d_ack;
  assign if_rdata     = rdata_q;
  assign d_rdata      = rdata_q;
  assign state_dbg    = state;

  always_comb begin
    state_d   = state;
    m_req_d   = m_req;
    m_we_d    = m_we;
    m_sel_d   = m_sel;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    rdata_d   = rdata_q;
    if_ack_d  = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    wait_d    = wait_cnt;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        wait_d = '0;
        if (d_req && (starve_cnt < STARVE_MAX || !if_req)) begin
          state_d   = GNT_D;
          grant_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_sel_d   = d_sel;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (if_req && !flush) begin
          state_d   = GNT_I;
          grant_i   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_sel_d   = '1;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
        end
      end
      GNT_I, GNT_D, DROP: begin
        if (wait_cnt != '1) wait_d = wait_cnt + 1'b1;
        if (m_ack || timeout_hit) begin
          m_req_d   = 1'b0;
          bus_err_d = timeout_hit;
          // A flush racing the completion still discards the fetched word.
          if (state == DROP || (state == GNT_I && flush)) begin
            state_d = IDLE;
          end else begin
            state_d  = RESP;
            rdata_d  = m_ack ? m_rdata : '0;
            if_ack_d = (state == GNT_I);
            d_ack_d  = (state == GNT_D);
          end
        end else if (state == GNT_I && flush) begin
          state_d = DROP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counts data grants taken while a fetch is waiting; a fetch grant or an idle fetch port clears it.
  always_comb begin
    starve_d = starve_cnt;
    if (!if_req || grant_i) starve_d = '0;
    else if (grant_d && starve_cnt != STARVE_MAX) starve_d = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_sel      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rdata_q    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_d;
      m_req      <= m_req_d;
      m_we       <= m_we_d;
      m_sel      <= m_sel_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      rdata_q    <= rdata_d;
      if_ack     <= if_ack_d;
      d_ack      <= d_ack_d;
      bus_err    <= bus_err_d;
      starve_cnt <= starve_d;
      wait_cnt   <= wait_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory slave model, directed timing scenarios and randomized
// dual-requester traffic, with acks checked from expected queues filled by a reference memory.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;
  localparam logic [2:0] IDLE_ST = 3'd0;

  logic        clk = 1'b0;
  logic        rst, flush, if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel, m_sel;
  logic        m_req, m_we, m_ack, stallreq_if, stallreq_mem, bus_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int bus_err_count = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  int ack_delay = 0;
  bit ack_never = 0;
  bit rand_delay = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input int c, input logic mr, input logic ia,
                     input logic da, input logic si, input logic be);
    @(negedge clk);
    chk($sformatf("%s c%0d m_req", tag, c), m_req, mr);
    chk($sformatf("%s c%0d if_ack", tag, c), if_ack, ia);
    chk($sformatf("%s c%0d d_ack", tag, c), d_ack, da);
    chk($sformatf("%s c%0d stallreq_if", tag, c), stallreq_if, si);
    chk($sformatf("%s c%0d bus_err", tag, c), bus_err, be);
    tick();
  endtask

  // Memory slave: acks ack_delay cycles after m_req rises; writes return the old word.
  initial begin
    int cnt;
    cnt = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      tick();
      m_ack = 1'b0;
      if (m_req && !ack_never) begin
        if (cnt >= ack_delay) begin
          m_ack = 1'b1;
          cnt = 0;
          m_rdata = slave_read(m_addr);
          if (m_we) slave_mem[m_addr] = merge(slave_read(m_addr), m_wdata, m_sel);
          if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected read data on every ack and checks bus-level rules.
  initial begin
    logic        prev_mreq;
    logic [31:0] prev_addr, prev_wdata;
    logic [4:0]  prev_ctl;
    int          d_during_wait;
    prev_mreq = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    prev_ctl = '0;
    d_during_wait = 0;
    forever begin
      @(negedge clk);
      chk("stallreq_if", stallreq_if, if_req & ~if_ack);
      chk("stallreq_mem", stallreq_mem, d_req & ~d_ack);
      if (if_ack) begin
        if (exp_if_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL if_ack_unexpected: got ack with if_rdata %h, expected no ack", if_rdata);
        end else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (d_ack) begin
        if (exp_d_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL d_ack_unexpected: got ack with d_rdata %h, expected no ack", d_rdata);
        end else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
      if (if_ack && d_ack) begin
        vectors++; miscompares++;
        $display("FAIL dual_ack: got if_ack=1 d_ack=1, expected at most one");
      end
      if (bus_err) bus_err_count++;
      if (if_ack) begin
        vectors++;
        if (d_during_wait > STARVE_LIMIT + 1) begin
          miscompares++;
          $display("FAIL starve_bound: got %0d data acks while fetch waited, expected <= %0d",
                   d_during_wait, STARVE_LIMIT + 1);
        end
        d_during_wait = 0;
      end else if (!if_req) d_during_wait = 0;
      else if (d_ack) d_during_wait++;
      if (m_req && prev_mreq) begin
        chk("m_addr_stable", m_addr, prev_addr);
        chk("m_wdata_stable", m_wdata, prev_wdata);
        chk("m_ctl_stable", {27'b0, m_we, m_sel}, {27'b0, prev_ctl});
      end
      prev_mreq = m_req;
      prev_addr = m_addr;
      prev_wdata = m_wdata;
      prev_ctl = {m_we, m_sel};
    end
  end

  task automatic fetch_driver(input int n);
    logic [31:0] a;
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      exp_if_q.push_back(ref_read(a));
      if_addr = a;
      if_req = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!if_ack && t < 300);
      if (!if_ack) begin
        vectors++; miscompares++;
        $display("FAIL fetch_wait: got no if_ack in %0d cycles, expected an ack", t);
      end
      tick();
      if_req = 1'b0;
    end
  endtask

  task automatic data_driver(input int n);
    logic [31:0] a, wd;
    logic [3:0]  s;
    logic        w;
    int          t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      a  = 32'h200 + (32'($urandom_range(0, 7)) << 2);
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(1, 15));
      wd = $urandom();
      exp_d_q.push_back(ref_read(a));
      if (w) ref_mem[a] = merge(ref_read(a), wd, s);
      d_addr = a; d_we = w; d_sel = s; d_wdata = wd; d_req = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!d_ack && t < 300);
      if (!d_ack) begin
        vectors++; miscompares++;
        $display("FAIL data_wait: got no d_ack in %0d cycles, expected an ack", t);
      end
      tick();
      d_req = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] kinds;
    logic       mr_prev, fire;
    int         grants, dacks;
    bit         done;

    rst = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset m_req", m_req, 1'b0);
    chk("reset if_ack", if_ack, 1'b0);
    chk("reset d_ack", d_ack, 1'b0);
    chk("reset bus_err", bus_err, 1'b0);
    chk("reset state", state_dbg, IDLE_ST);
    chk("reset d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // 1: lone fetch, m_ack two cycles after m_req
    ref_mem[32'h100] = 32'h3C010001;
    slave_mem[32'h100] = 32'h3C010001;
    ack_delay = 2;
    if_addr = 32'h100; if_req = 1'b1;
    exp_if_q.push_back(ref_read(32'h100));
    cyc("t1", 0, 0, 0, 0, 1, 0);
    chk("t1 m_addr", m_addr, 32'h100);
    cyc("t1", 1, 1, 0, 0, 1, 0);
    cyc("t1", 2, 1, 0, 0, 1, 0);
    cyc("t1", 3, 1, 0, 0, 1, 0);
    cyc("t1", 4, 0, 1, 0, 0, 0);
    if_req = 1'b0;
    cyc("t1", 5, 0, 0, 0, 0, 0);

    // 2: simultaneous fetch and data read; data goes first
    ack_delay = 0;
    if_addr = 32'h104; if_req = 1'b1;
    d_addr = 32'h200; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    exp_d_q.push_back(ref_read(32'h200));
    exp_if_q.push_back(ref_read(32'h104));
    cyc("t2", 0, 0, 0, 0, 1, 0);
    chk("t2 data first m_addr", m_addr, 32'h200);
    cyc("t2", 1, 1, 0, 0, 1, 0);
    cyc("t2", 2, 0, 0, 1, 1, 0);
    d_req = 1'b0;
    cyc("t2", 3, 0, 0, 0, 1, 0);
    chk("t2 fetch second m_addr", m_addr, 32'h104);
    cyc("t2", 4, 1, 0, 0, 1, 0);
    cyc("t2", 5, 0, 1, 0, 0, 0);
    if_req = 1'b0;
    cyc("t2", 6, 0, 0, 0, 0, 0);

    // 3: data held continuously against a waiting fetch
    if_addr = 32'h108; if_req = 1'b1;
    d_addr = 32'h204; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    exp_if_q.push_back(ref_read(32'h108));
    repeat (STARVE_LIMIT + 1) exp_d_q.push_back(ref_read(32'h204));
    kinds = '0; grants = 0; dacks = 0; done = 0; mr_prev = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (m_req && !mr_prev && grants < 8) begin
        kinds[grants] = (m_addr == 32'h108);
        grants++;
      end
      mr_prev = m_req;
      if (d_ack) dacks++;
      fire = if_ack;
      tick();
      if (fire) if_req = 1'b0;
      if (dacks == STARVE_LIMIT + 1) begin
        d_req = 1'b0;
        done = 1;
      end
    end
    chk("t3 completed", done, 1'b1);
    chk("t3 grant count", grants, STARVE_LIMIT + 2);
    for (int i = 0; i <= STARVE_LIMIT + 1; i++)
      chk($sformatf("t3 grant%0d is_fetch", i), kinds[i], (i == STARVE_LIMIT));
    tick();

    // 4: flush one cycle after the fetch grant
    ack_delay = 3;
    if_addr = 32'h10C; if_req = 1'b1;
    cyc("t4", 0, 0, 0, 0, 1, 0);
    flush = 1'b1;
    cyc("t4", 1, 1, 0, 0, 1, 0);
    flush = 1'b0; if_req = 1'b0;
    cyc("t4", 2, 1, 0, 0, 0, 0);
    cyc("t4", 3, 1, 0, 0, 0, 0);
    cyc("t4", 4, 1, 0, 0, 0, 0);
    chk("t4 state idle", state_dbg, IDLE_ST);
    cyc("t4", 5, 0, 0, 0, 0, 0);
    cyc("t4", 6, 0, 0, 0, 0, 0);

    // 5: memory never acks; timeout ends the data transaction with zero data
    ack_never = 1;
    d_addr = 32'h208; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    exp_d_q.push_back(32'h0);
    for (int c = 0; c <= TIMEOUT + 3; c++) begin
      cyc("t5", c, (c >= 1 && c <= TIMEOUT + 1), 0, (c == TIMEOUT + 2), 0, (c == TIMEOUT + 2));
      if (c == TIMEOUT + 2) d_req = 1'b0;
    end
    ack_never = 0;

    // 6: reset in the middle of a data grant, then a clean transaction
    ack_delay = 5;
    d_addr = 32'h20C; d_we = 1'b1; d_sel = 4'hF; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    cyc("t6", 0, 0, 0, 0, 0, 0);
    cyc("t6", 1, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6 async m_req", m_req, 1'b0);
    chk("t6 async state", state_dbg, IDLE_ST);
    chk("t6 async d_ack", d_ack, 1'b0);
    chk("t6 async bus_err", bus_err, 1'b0);
    d_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    tick();
    ack_delay = 1;
    d_addr = 32'h20C; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    exp_d_q.push_back(ref_read(32'h20C));
    cyc("t6b", 0, 0, 0, 0, 0, 0);
    cyc("t6b", 1, 1, 0, 0, 0, 0);
    cyc("t6b", 2, 1, 0, 0, 0, 0);
    cyc("t6b", 3, 0, 0, 1, 0, 0);
    d_req = 1'b0;
    cyc("t6b", 4, 0, 0, 0, 0, 0);

    // Randomized contention between both requesters
    rand_delay = 1;
    ack_delay = $urandom_range(0, 3);
    fork
      fetch_driver(120);
      data_driver(120);
    join
    repeat (6) tick();

    chk("end if queue empty", exp_if_q.size(), 0);
    chk("end d queue empty", exp_d_q.size(), 0);
    chk("bus_err pulses", bus_err_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
